// File: rtl/sram_read_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_read_arbiter_if
// Bundles the requester handshake, the response return path and the SRAM
// read port of sram_read_arbiter.
//
//   req_valid / req_ready        per-requester burst request and one-hot accept
//   req_base_addr / req_len      packed burst start addresses / lengths minus one
//   rsp_valid / rsp_last         one-hot response strobe and final-word marker
//   rsp_data                     read data shared by all requesters
//   busy                         burst issuing or a read still in flight
//   dut__tb__sram_read_address   SRAM read address driven by the arbiter
//   tb__dut__sram_read_data      SRAM read data, one cycle after its address
//
// The slave modport is the arbiter's view; master is the requester/SRAM side.
// ---------------------------------------------------------------------------
interface sram_read_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_base_addr;
    logic [NUM_REQ*LEN_W-1:0]  req_len;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ-1:0]        rsp_last;
    logic [DATA_W-1:0]         rsp_data;
    logic                      busy;
    logic [ADDR_W-1:0]         dut__tb__sram_read_address;
    logic [DATA_W-1:0]         tb__dut__sram_read_data;

    modport slave (
        input  req_valid,
        input  req_base_addr,
        input  req_len,
        input  tb__dut__sram_read_data,
        output req_ready,
        output rsp_valid,
        output rsp_last,
        output rsp_data,
        output busy,
        output dut__tb__sram_read_address
    );

    modport master (
        output req_valid,
        output req_base_addr,
        output req_len,
        output tb__dut__sram_read_data,
        input  req_ready,
        input  rsp_valid,
        input  rsp_last,
        input  rsp_data,
        input  busy,
        input  dut__tb__sram_read_address
    );
endinterface

// File: rtl/sram_read_arbiter.sv
// ---------------------------------------------------------------------------
// sram_read_arbiter
// Shares one SRAM read port between NUM_REQ requesters. Each requester asks
// for a burst of req_len+1 consecutive words starting at req_base_addr.
// Bursts are granted round-robin, one at a time, and each returned word is
// steered to the owning requester one cycle after its address.
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    sram_read_arbiter_if.slave (request, response and SRAM signals)
//
// States:
//   IDLE  | no burst issuing; search for a winner, accept it, latch its burst
//   BURST | drive base+cnt to the SRAM each cycle until cnt reaches len
// ---------------------------------------------------------------------------
module sram_read_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    sram_read_arbiter_if.slave    bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t             state, state_nxt;

    logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [PTR_W-1:0]   cur_id, cur_id_nxt;
    logic [ADDR_W-1:0]  cur_base, cur_base_nxt;
    logic [LEN_W-1:0]   cur_len, cur_len_nxt;
    logic [LEN_W-1:0]   cnt, cnt_nxt;

    logic               found;
    logic [PTR_W-1:0]   win_id;
    logic [ADDR_W-1:0]  win_base;
    logic [LEN_W-1:0]   win_len;
    int                 scan_idx;

    logic [NUM_REQ-1:0] ready_vec;
    logic [ADDR_W-1:0]  rd_addr;
    logic               issue_valid;
    logic               issue_last;

    // response pipeline: tags the word whose address went out last cycle
    logic               pipe_valid;
    logic [PTR_W-1:0]   pipe_id;
    logic               pipe_last;

    // Round-robin search: start at rr_ptr, wrap modulo NUM_REQ, first set wins.
    always_comb begin
        found    = 1'b0;
        win_id   = '0;
        scan_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!found && bus.req_valid[scan_idx]) begin
                found  = 1'b1;
                win_id = PTR_W'(scan_idx);
            end
        end
    end

    assign win_base = bus.req_base_addr[int'(win_id)*ADDR_W +: ADDR_W];
    assign win_len  = bus.req_len[int'(win_id)*LEN_W +: LEN_W];

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        cur_id_nxt   = cur_id;
        cur_base_nxt = cur_base;
        cur_len_nxt  = cur_len;
        cnt_nxt      = cnt;
        ready_vec    = '0;
        rd_addr      = '0;
        issue_valid  = 1'b0;
        issue_last   = 1'b0;

        case (state)
            IDLE: begin
                if (found) begin
                    ready_vec[win_id] = 1'b1;
                    cur_id_nxt        = win_id;
                    cur_base_nxt      = win_base;
                    cur_len_nxt       = win_len;
                    cnt_nxt           = '0;
                    rr_ptr_nxt        = (win_id == PTR_W'(NUM_REQ - 1)) ? '0
                                                                        : win_id + PTR_W'(1);
                    state_nxt         = BURST;
                end
            end
            BURST: begin
                // address wraps silently past all-ones
                rd_addr     = cur_base + ADDR_W'(cnt);
                issue_valid = 1'b1;
                issue_last  = (cnt == cur_len);
                cnt_nxt     = cnt + LEN_W'(1);
                if (issue_last) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            cur_id     <= '0;
            cur_base   <= '0;
            cur_len    <= '0;
            cnt        <= '0;
            pipe_valid <= 1'b0;
            pipe_id    <= '0;
            pipe_last  <= 1'b0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_ptr_nxt;
            cur_id     <= cur_id_nxt;
            cur_base   <= cur_base_nxt;
            cur_len    <= cur_len_nxt;
            cnt        <= cnt_nxt;
            pipe_valid <= issue_valid;
            pipe_id    <= cur_id;
            pipe_last  <= issue_last;
        end
    end

    assign bus.req_ready                  = ready_vec;
    assign bus.dut__tb__sram_read_address = rd_addr;
    assign bus.rsp_valid                  = pipe_valid ? (NUM_REQ'(1) << pipe_id) : '0;
    assign bus.rsp_last                   = (pipe_valid && pipe_last) ? (NUM_REQ'(1) << pipe_id) : '0;
    // SRAM has a fixed 1-cycle latency, so its output lines up with pipe_*
    assign bus.rsp_data                   = bus.tb__dut__sram_read_data;
    assign bus.busy                       = (state == BURST) | pipe_valid;

endmodule

// File: doc/sram_read_arbiter.md
Name: sram_read_arbiter

Overview:
- Shares one SRAM read port (weight or scratchpad) between NUM_REQ requesters, e.g. several MAC engines or a MAC engine plus a prefetch path.
- Each requester asks for a burst of consecutive words (base address plus length).
- Grants are round-robin, one burst at a time; the arbiter drives the SRAM read address each cycle.
- Returned data is steered back to the owning requester, aligned with the SRAM's 1-cycle read latency.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_W, 12, SRAM address width
- DATA_W, 32, SRAM data width
- LEN_W, 8, burst length field width; a burst is req_len+1 words (1..2^LEN_W)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester burst request, held until accepted
- req_ready  out  NUM_REQ  one-hot accept pulse; handshake completes when req_valid[i] and req_ready[i] are both high
- req_base_addr  in  NUM_REQ*ADDR_W  packed burst start addresses; slice i belongs to requester i
- req_len  in  NUM_REQ*LEN_W  packed burst lengths minus one
- rsp_valid  out  NUM_REQ  one-hot: rsp_data is valid for requester i
- rsp_last  out  NUM_REQ  one-hot: marks the final word of requester i's burst
- rsp_data  out  DATA_W  read data, shared by all requesters
- busy  out  1  burst issuing or a read still in flight
- dut__tb__sram_read_address  out  ADDR_W  SRAM read address
- tb__dut__sram_read_data  in  DATA_W  SRAM read data; valid the cycle after its address

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; rr_ptr points so requester 0 has highest priority.
  - req_ready, rsp_valid, rsp_last, busy, read address and the response pipeline register all go to 0.
- Reset mid-burst:
  - Aborts the burst; no rsp_valid appears for the in-flight word.
  - Takes priority over every other event in the same cycle.
- State IDLE:
  - Requester search starts at rr_ptr and wraps modulo NUM_REQ; the first requester with req_valid set wins.
  - In that cycle: req_ready[w]=1 (combinational from state and req_valid); latch base/len/id of w; cnt=0; rr_ptr <= (w+1) mod NUM_REQ; next state BURST.
  - With no requests: stay in IDLE, address output 0, rr_ptr unchanged.
- State BURST:
  - Address = (base + cnt) mod 2^ADDR_W; wraps past all-ones to 0 with no error.
  - cnt increments each cycle.
  - When cnt == len: this is the final address; next state is IDLE.
- Response pipeline:
  - Registers {issue_valid, id, last} each BURST cycle.
  - Next cycle: rsp_valid[id]=1, rsp_data = tb__dut__sram_read_data (passed through combinationally), and rsp_last[id]=1 if the word is final.
- Inter-burst gap: exactly one IDLE cycle between bursts.
  - The IDLE cycle overlaps the previous burst's last data return.
- Downstream rules: no backpressure on responses; consumers must accept every rsp_valid word.
- req_valid handling:
  - Dropping req_valid before acceptance withdraws the request; this is legal.
  - Inputs are sampled only in the grant cycle.
  - A requester whose burst was just accepted may re-request immediately; fairness comes from rr_ptr.
- Output encodings:
  - busy = (state==BURST) | response-pipeline valid.
  - req_ready, rsp_valid and rsp_last are each at most one-hot every cycle.
- Length: req_len=0 is a 1-word burst, so rsp_last coincides with the only rsp_valid.

Test Plan:
- Single burst:
  - Stimulus: requester 0 only, base 0x010, len 3, grant at cycle T.
  - Required: req_ready[0] high at T; addresses 0x010..0x013 at T+1..T+4; rsp_valid[0] at T+2..T+5; rsp_last[0] only at T+5; busy falls at T+6.
- Contention:
  - Stimulus: requesters 0 and 1 both valid from reset, each len 1, both re-requesting continuously.
  - Required: grants go 0,1,0,1; each grant lands 3 cycles after the previous one; rsp_valid never asserts for the non-owner.
- Wrap:
  - Stimulus: base 0xFFE, len 3, ADDR_W=12.
  - Required: addresses 0xFFE, 0xFFF, 0x000, 0x001.
- Data routing:
  - Stimulus: SRAM model returns mem[a]=3*a; requester 1 bursts base 0x020, len 2.
  - Required: rsp_data 0x060, 0x063, 0x066 with rsp_valid[1]; rsp_valid[0] stays 0.
- Reset mid-burst:
  - Stimulus: assert reset during the 2nd BURST cycle of a len 7 burst.
  - Required: next cycle rsp_valid=0, address 0, busy=0, state IDLE; after release, requester 0 wins over a simultaneous requester 1.
- Single-word burst:
  - Stimulus: len 0, base 0x100.
  - Required: one address 0x100; one rsp_valid together with rsp_last; the next grant is possible 2 cycles after the first grant.
